if_prefetch: RTL and testbench

//  Instruction-fetch front end that sits between the core's fetch port and inst_rom.

---
 rtl/if_prefetch_pkg.sv | 25 ++
 rtl/if_prefetch_if.sv | 28 ++
 rtl/if_fifo.sv | 60 ++++++
 rtl/if_prefetch.sv | 83 ++++++++
 tb/tb_if_prefetch.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch prefetch front end.
package if_prefetch_pkg;

  typedef logic [31:0] inst_addr_t;
  typedef logic [31:0] inst_t;

  localparam logic       RST_ENABLE = 1'b0;
  localparam inst_addr_t INST_STEP  = 32'd4;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fetch_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_t;

  // Instruction addresses are word aligned; the low two bits are dropped.
  function automatic inst_addr_t align_word(input inst_addr_t addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// ROM fetch port, ID handshake and redirect bundle for if_prefetch.
interface if_prefetch_if #(
  parameter int DEPTH = 4
);
  import if_prefetch_pkg::*;

  inst_addr_t                   rom_addr_o;
  logic                         rom_ce_o;
  inst_t                        rom_data_i;
  logic                         id_valid_o;
  logic                         id_ready_i;
  inst_addr_t                   id_pc_o;
  inst_t                        id_inst_o;
  logic                         redirect_i;
  inst_addr_t                   redirect_pc_i;
  logic [$clog2(DEPTH+1)-1:0]   fill_cnt_o;

  modport master (
    output rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o, fill_cnt_o,
    input  rom_data_i, id_ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  rom_addr_o, rom_ce_o, id_valid_o, id_pc_o, id_inst_o, fill_cnt_o,
    output rom_data_i, id_ready_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/if_fifo.sv
// Synchronous FIFO holding {pc, inst} pairs; flush empties it in one cycle.
module if_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH+1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count
);
  import if_prefetch_pkg::*;

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign push_ok = push & ~flush & (count != FULL_CNT);
  assign pop_ok  = pop  & ~flush & (count != '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: streams ROM words into a small FIFO and hands
// {pc, inst} to ID over valid/ready; a redirect flushes and restarts fetch.
//
// state   | meaning
// ST_IDLE | in or just out of reset, no fetch yet
// ST_RUN  | fetching whenever the buffer has room and no redirect is pending
module if_prefetch
  import if_prefetch_pkg::*;
#(
  parameter int         DEPTH    = 4,
  parameter inst_addr_t RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  if_prefetch_if.master      bus
);

  localparam int            CW       = $clog2(DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  fetch_state_t  state_q;
  fetch_state_t  state_d;
  inst_addr_t    pc_q;
  logic [CW-1:0] count;
  fetch_entry_t  push_entry;
  fetch_entry_t  head;
  logic [63:0]   head_raw;
  logic          fetch;
  logic          id_valid;
  logic          pop;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE) state_q <= ST_IDLE;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  // Redirect blanks both sides for the cycle so stale entries never leak out.
  assign fetch    = (state_q == ST_RUN) & (count != FULL_CNT) & ~bus.redirect_i;
  assign id_valid = (count != '0) & ~bus.redirect_i;
  assign pop      = id_valid & bus.id_ready_i;

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RST_ENABLE)  pc_q <= RESET_PC;
    else if (bus.redirect_i) pc_q <= align_word(bus.redirect_pc_i);
    else if (fetch)          pc_q <= pc_q + INST_STEP;
  end

  assign push_entry.pc   = pc_q;
  assign push_entry.inst = bus.rom_data_i;

  if_fifo #(
    .DEPTH (DEPTH),
    .W     (64)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fetch),
    .pop   (pop),
    .flush (bus.redirect_i),
    .din   (push_entry),
    .dout  (head_raw),
    .count (count)
  );

  assign head = head_raw;

  assign bus.rom_addr_o = pc_q;
  assign bus.rom_ce_o   = fetch;
  assign bus.id_valid_o = id_valid;
  assign bus.id_pc_o    = head.pc;
  assign bus.id_inst_o  = head.inst;
  assign bus.fill_cnt_o = count;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed and randomised checks of if_prefetch against a ROM whose word is addr^A5A5_0000.
module tb_if_prefetch;

  localparam logic [31:0] ROM_KEY = 32'hA5A5_0000;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  if_prefetch_if #(.DEPTH(4)) bus ();

  assign bus.rom_data_i = bus.rom_addr_o ^ ROM_KEY;

  if_prefetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_pc;
    int          n;
    int          fetches;
    int          delivered;

    rst               = 1'b0;
    bus.id_ready_i    = 1'b1;
    bus.redirect_i    = 1'b0;
    bus.redirect_pc_i = 32'h0;
    #2;
    chk("rst_ce",    64'(bus.rom_ce_o),   64'd0);
    chk("rst_addr",  64'(bus.rom_addr_o), 64'd0);
    chk("rst_valid", 64'(bus.id_valid_o), 64'd0);
    chk("rst_pc",    64'(bus.id_pc_o),    64'd0);
    chk("rst_inst",  64'(bus.id_inst_o),  64'd0);
    chk("rst_fill",  64'(bus.fill_cnt_o), 64'd0);

    // 1: start-up latency and one-per-cycle streaming
    cyc(); rst = 1'b1; #1;
    chk("t1_ce_idle", 64'(bus.rom_ce_o), 64'd0);
    cyc();
    chk("t1_ce_first",   64'(bus.rom_ce_o),   64'd1);
    chk("t1_addr_first", 64'(bus.rom_addr_o), 64'd0);
    chk("t1_valid_first",64'(bus.id_valid_o), 64'd0);
    for (int i = 0; i < 6; i++) begin
      cyc();
      chk("t1_valid", 64'(bus.id_valid_o), 64'd1);
      chk("t1_pc",    64'(bus.id_pc_o),    64'(32'(4*i)));
      chk("t1_inst",  64'(bus.id_inst_o),  64'(32'(4*i) ^ ROM_KEY));
    end
    chk("t1_fill", 64'(bus.fill_cnt_o), 64'd1);

    // 2: ID stalled -> exactly DEPTH fetches, head held, then gapless resume
    rst = 1'b0; bus.id_ready_i = 1'b0;
    cyc(); rst = 1'b1;
    fetches = 0;
    for (int i = 0; i < 10; i++) begin
      cyc(); #1;
      if (bus.rom_ce_o) fetches++;
      if (bus.id_valid_o) chk("t2_head_held", 64'(bus.id_pc_o), 64'd0);
    end
    chk("t2_fetches", 64'(fetches),        64'd4);
    chk("t2_fill",    64'(bus.fill_cnt_o), 64'd4);
    chk("t2_ce",      64'(bus.rom_ce_o),   64'd0);
    chk("t2_addr",    64'(bus.rom_addr_o), 64'd16);
    chk("t2_valid",   64'(bus.id_valid_o), 64'd1);
    bus.id_ready_i = 1'b1;
    exp_pc = 32'h0; n = 0;
    for (int k = 0; k < 20 && n < 6; k++) begin
      #1;
      if (bus.id_valid_o) begin
        chk("t2_pc", 64'(bus.id_pc_o), 64'(exp_pc));
        exp_pc = exp_pc + 32'd4; n++;
      end
      cyc();
    end
    chk("t2_count", 64'(n), 64'd6);

    // 3: redirect with fill=3, unaligned target
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0103; #1;
    chk("t3_fill_before", 64'(bus.fill_cnt_o), 64'd3);
    chk("t3_valid_rd",    64'(bus.id_valid_o), 64'd0);
    chk("t3_ce_rd",       64'(bus.rom_ce_o),   64'd0);
    cyc(); bus.redirect_i = 1'b0; #1;
    chk("t3_addr",  64'(bus.rom_addr_o), 64'h100);
    chk("t3_fill",  64'(bus.fill_cnt_o), 64'd0);
    chk("t3_ce",    64'(bus.rom_ce_o),   64'd1);
    chk("t3_valid0",64'(bus.id_valid_o), 64'd0);
    cyc(); #1;
    chk("t3_valid", 64'(bus.id_valid_o), 64'd1);
    chk("t3_pc",    64'(bus.id_pc_o),    64'h100);
    chk("t3_inst",  64'(bus.id_inst_o),  64'(32'h100 ^ ROM_KEY));
    cyc(); #1;
    chk("t3_pc_next", 64'(bus.id_pc_o),  64'h104);

    // 4: redirect near the top of the address space, PC wraps
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'hFFFF_FFF8;
    cyc(); bus.redirect_i = 1'b0;
    exp_pc = 32'hFFFF_FFF8; n = 0;
    for (int k = 0; k < 12 && n < 4; k++) begin
      #1;
      if (bus.id_valid_o) begin
        chk("t4_pc",   64'(bus.id_pc_o),   64'(exp_pc));
        chk("t4_inst", 64'(bus.id_inst_o), 64'(exp_pc ^ ROM_KEY));
        exp_pc = exp_pc + 32'd4; n++;
      end
      cyc();
    end
    chk("t4_count", 64'(n), 64'd4);

    // 5: asynchronous reset mid-cycle with fill=2
    bus.id_ready_i = 1'b0;
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_0200;
    cyc(); bus.redirect_i = 1'b0;
    cyc(); cyc(); #1;
    chk("t5_fill_before", 64'(bus.fill_cnt_o), 64'd2);
    #2; rst = 1'b0; #1;
    chk("t5_ce",    64'(bus.rom_ce_o),   64'd0);
    chk("t5_addr",  64'(bus.rom_addr_o), 64'd0);
    chk("t5_valid", 64'(bus.id_valid_o), 64'd0);
    chk("t5_pc",    64'(bus.id_pc_o),    64'd0);
    chk("t5_inst",  64'(bus.id_inst_o),  64'd0);
    chk("t5_fill",  64'(bus.fill_cnt_o), 64'd0);
    cyc(); rst = 1'b1; bus.id_ready_i = 1'b1; #1;
    chk("t5_ce_idle", 64'(bus.rom_ce_o), 64'd0);
    cyc(); #1;
    chk("t5_ce_run",  64'(bus.rom_ce_o),   64'd1);
    chk("t5_addr_run",64'(bus.rom_addr_o), 64'd0);
    cyc(); #1;
    chk("t5_valid_run", 64'(bus.id_valid_o), 64'd1);
    chk("t5_pc_run",    64'(bus.id_pc_o),    64'd0);

    // 6: random ready/redirect stress against an in-order scoreboard
    bus.redirect_i = 1'b1; bus.redirect_pc_i = 32'h0000_1000;
    exp_pc = 32'h0000_1000; delivered = 0;
    cyc();
    for (int i = 0; i < 10000; i++) begin
      bus.id_ready_i    = ($urandom_range(0, 9) < 7);
      bus.redirect_i    = ($urandom_range(0, 31) == 0);
      bus.redirect_pc_i = $urandom;
      #1;
      chk("t6_fill_bound", 64'(bus.fill_cnt_o <= 3'd4), 64'd1);
      if (bus.redirect_i) begin
        chk("t6_rd_quiet", 64'({bus.id_valid_o, bus.rom_ce_o}), 64'd0);
        exp_pc = bus.redirect_pc_i & ~32'h3;
      end else if (bus.id_valid_o && bus.id_ready_i) begin
        chk("t6_pc",   64'(bus.id_pc_o),   64'(exp_pc));
        chk("t6_inst", 64'(bus.id_inst_o), 64'(exp_pc ^ ROM_KEY));
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      cyc();
    end
    chk("t6_progress", 64'(delivered > 1000), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
